deck_access_arbiter: RTL and testbench

//  Arbitrates the single card deck between the player and dealer hand controllers. Latches

---
 rtl/deck_access_arbiter.sv | 137 +++++++++++++
 tb/tb_deck_access_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deck_access_arbiter.sv
// Shares one card deck between the player and dealer hands: latches draw pulses, issues one
// deck request at a time, routes the returned card to the winning hand and sequences reshuffles.
module deck_access_arbiter #(
  parameter int CARD_W       = 4,
  parameter int DECK_SIZE    = 52,
  parameter int RESHUFFLE_AT = 40,
  localparam int CNT_W       = $clog2(DECK_SIZE + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_playerReq,
  input  logic              i_dealerReq,
  input  logic              i_roundStart,
  output logic              o_deckReq,
  input  logic              i_deckValid,
  input  logic [CARD_W-1:0] i_deckCard,
  output logic              o_shuffleStart,
  input  logic              i_shuffleDone,
  output logic              o_playerValid,
  output logic              o_dealerValid,
  output logic [CARD_W-1:0] o_card,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_cardsDealt,
  output logic [2:0]        o_state
);

  // Handshakes are pulse based, not valid/ready: a req pulse is remembered until its card is
  // delivered, o_deckReq/o_shuffleStart are single-cycle commands, and i_deckValid is only
  // accepted in S_WAIT and i_shuffleDone only in S_SHUF_WAIT; both are ignored elsewhere.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT      = 3'd2,
    S_DELIVER   = 3'd3,
    S_SHUFFLE   = 3'd4,
    S_SHUF_WAIT = 3'd5
  } state_t;

  localparam logic GRANT_P = 1'b1;
  localparam logic GRANT_D = 1'b0;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DECK_SIZE);
  localparam logic [CNT_W-1:0] RESH_CNT = CNT_W'(RESHUFFLE_AT);

  state_t             state;
  state_t             state_next;
  logic               grant;
  logic               grant_next;
  logic               last_grant;
  logic               pend_p;
  logic               pend_d;
  logic               shuf_pend;
  logic [CNT_W-1:0]   count;
  logic [CARD_W-1:0]  card_q;

  logic in_shuffle;
  logic deliver_p;
  logic deliver_d;
  logic shuffle_done;
  logic card_accept;

  assign in_shuffle   = (state == S_SHUFFLE) || (state == S_SHUF_WAIT);
  assign deliver_p    = (state == S_DELIVER) && (grant == GRANT_P);
  assign deliver_d    = (state == S_DELIVER) && (grant == GRANT_D);
  assign shuffle_done = (state == S_SHUF_WAIT) && i_shuffleDone;
  assign card_accept  = (state == S_WAIT) && i_deckValid;

  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      S_IDLE: begin
        if ((count == FULL_CNT) || shuf_pend) begin
          state_next = S_SHUFFLE;
        end else if (pend_p || pend_d) begin
          state_next = S_ISSUE;
          // Under contention the side that was not served last time wins.
          if (pend_p && pend_d) grant_next = ~last_grant;
          else                  grant_next = pend_p ? GRANT_P : GRANT_D;
        end
      end
      S_ISSUE:     state_next = S_WAIT;
      S_WAIT:      if (i_deckValid) state_next = S_DELIVER;
      S_DELIVER:   state_next = S_IDLE;
      S_SHUFFLE:   state_next = S_SHUF_WAIT;
      S_SHUF_WAIT: if (i_shuffleDone) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      grant      <= GRANT_D;
      last_grant <= GRANT_D;
      pend_p     <= 1'b0;
      pend_d     <= 1'b0;
      shuf_pend  <= 1'b0;
      count      <= '0;
      card_q     <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      // A fresh pulse in the delivery cycle outranks the clear, so it is not lost.
      pend_p <= i_playerReq | (pend_p & ~deliver_p);
      pend_d <= i_dealerReq | (pend_d & ~deliver_d);
      if (shuffle_done) begin
        shuf_pend <= 1'b0;
      end else if (i_roundStart && !in_shuffle && (count >= RESH_CNT)) begin
        shuf_pend <= 1'b1;
      end
      if (shuffle_done) begin
        count <= '0;
      end else if ((state == S_DELIVER) && (count != FULL_CNT)) begin
        count <= count + 1'b1;
      end
      if (state == S_DELIVER) last_grant <= grant;
      if (card_accept) card_q <= i_deckCard;
    end
  end

  assign o_deckReq      = (state == S_ISSUE);
  assign o_shuffleStart = (state == S_SHUFFLE);
  assign o_playerValid  = deliver_p;
  assign o_dealerValid  = deliver_d;
  assign o_card         = card_q;
  assign o_busy         = (state != S_IDLE);
  assign o_cardsDealt   = count;
  assign o_state        = state;

  a_valid_onehot: assert property (@(posedge i_clk) disable iff (i_reset)
    !(o_playerValid && o_dealerValid));
  a_count_bound: assert property (@(posedge i_clk) disable iff (i_reset)
    count <= FULL_CNT);
  a_no_req_when_full: assert property (@(posedge i_clk) disable iff (i_reset)
    (state == S_ISSUE) |-> (count != FULL_CNT));

endmodule

// File: tb/tb_deck_access_arbiter.sv
// Directed bench for deck_access_arbiter: table of single draws, then hand-written sequences
// for contention, reshuffle thresholds, forced shuffle at an empty deck and mid-draw reset.
module tb_deck_access_arbiter;

  localparam int CARD_W = 4;
  localparam int CNT_W  = 6;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_playerReq = 1'b0;
  logic              i_dealerReq = 1'b0;
  logic              i_roundStart = 1'b0;
  logic              o_deckReq;
  logic              i_deckValid = 1'b0;
  logic [CARD_W-1:0] i_deckCard = '0;
  logic              o_shuffleStart;
  logic              i_shuffleDone = 1'b0;
  logic              o_playerValid;
  logic              o_dealerValid;
  logic [CARD_W-1:0] o_card;
  logic              o_busy;
  logic [CNT_W-1:0]  o_cardsDealt;
  logic [2:0]        o_state;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  deck_access_arbiter dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_playerReq(i_playerReq), .i_dealerReq(i_dealerReq), .i_roundStart(i_roundStart),
    .o_deckReq(o_deckReq), .i_deckValid(i_deckValid), .i_deckCard(i_deckCard),
    .o_shuffleStart(o_shuffleStart), .i_shuffleDone(i_shuffleDone),
    .o_playerValid(o_playerValid), .o_dealerValid(o_dealerValid), .o_card(o_card),
    .o_busy(o_busy), .o_cardsDealt(o_cardsDealt), .o_state(o_state)
  );

  // clock / global bound
  always #5 i_clk = ~i_clk;

  initial begin
    #300000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench time limit reached");
  end

  always @(negedge i_clk) begin
    if (!i_reset) begin
      checks++;
      if (o_playerValid && o_dealerValid) begin
        failures++;
        $display("FAIL valid_exclusive actual=both_high required=at_most_one t=%0t", $time);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic pulse_req(input logic p, input logic d);
    i_playerReq = p;
    i_dealerReq = d;
    tick();
    i_playerReq = 1'b0;
    i_dealerReq = 1'b0;
  endtask

  // Returns the cycle offset (relative to the pulse cycle) at which o_deckReq is seen.
  task automatic wait_deck_req(input int start, output int at);
    at = start;
    while (!o_deckReq && at < start + 20) begin
      tick();
      at++;
    end
    check("deck_req_seen", {31'd0, o_deckReq}, 32'd1);
  endtask

  task automatic wait_shuffle(input int start, output int at);
    at = start;
    while (!o_shuffleStart && at < start + 20) begin
      tick();
      at++;
    end
    check("shuffle_start_seen", {31'd0, o_shuffleStart}, 32'd1);
  endtask

  // Called in the o_deckReq cycle; returns in the cycle the DUT should deliver.
  task automatic serve(input int lat, input logic [CARD_W-1:0] card);
    repeat (lat) tick();
    i_deckValid = 1'b1;
    i_deckCard  = card;
    tick();
    i_deckValid = 1'b0;
    i_deckCard  = 4'h0;
  endtask

  task automatic check_delivery(input logic ep, input logic ed, input logic [CARD_W-1:0] ecard,
                                input logic rp, input logic rd);
    check("player_valid", {31'd0, o_playerValid}, {31'd0, ep});
    check("dealer_valid", {31'd0, o_dealerValid}, {31'd0, ed});
    check("card", {28'd0, o_card}, {28'd0, ecard});
    i_playerReq = rp;
    i_dealerReq = rd;
    tick();
    i_playerReq = 1'b0;
    i_dealerReq = 1'b0;
    exp_count++;
    check("valid_one_cycle", {30'd0, o_playerValid, o_dealerValid}, 32'd0);
    check("card_held", {28'd0, o_card}, {28'd0, ecard});
    check("cards_dealt", {26'd0, o_cardsDealt}, exp_count);
  endtask

  task automatic single_draw(input logic player, input int lat, input logic [CARD_W-1:0] card);
    int at;
    pulse_req(player, ~player);
    wait_deck_req(1, at);
    check("deck_req_latency", at, 32'd2);
    serve(lat, card);
    check_delivery(player, ~player, card, 1'b0, 1'b0);
  endtask

  task automatic fill_to(input int n);
    while (exp_count < n) single_draw(1'b1, 1, 4'(exp_count));
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;
    exp_count = 0;
  endtask

  typedef struct {
    logic              player;
    int                lat;
    logic [CARD_W-1:0] card;
  } vec_t;

  vec_t vecs[4];

  // scoreboard: grant order expected under alternating contention
  logic [1:0] exp_q[$];

  initial begin
    int at;
    logic [1:0] g;
    logic [CARD_W-1:0] c;
    logic seen;

    vecs[0] = '{player: 1'b1, lat: 1, card: 4'h7};
    vecs[1] = '{player: 1'b0, lat: 3, card: 4'hF};
    vecs[2] = '{player: 1'b1, lat: 2, card: 4'h0};
    vecs[3] = '{player: 1'b0, lat: 1, card: 4'h5};

    do_reset();
    check("reset_deck_req", {31'd0, o_deckReq}, 32'd0);
    check("reset_shuffle_start", {31'd0, o_shuffleStart}, 32'd0);
    check("reset_valids", {30'd0, o_playerValid, o_dealerValid}, 32'd0);
    check("reset_card", {28'd0, o_card}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_count", {26'd0, o_cardsDealt}, 32'd0);

    for (int i = 0; i < 4; i++) single_draw(vecs[i].player, vecs[i].lat, vecs[i].card);

    // Both hands pulse together after reset: player wins, dealer follows.
    do_reset();
    pulse_req(1'b1, 1'b1);
    wait_deck_req(1, at);
    check("contend_first_latency", at, 32'd2);
    serve(1, 4'h3);
    check_delivery(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
    wait_deck_req(0, at);
    serve(1, 4'h9);
    check_delivery(1'b0, 1'b1, 4'h9, 1'b0, 1'b0);

    // Alternating contention: each served side re-requests in its delivery cycle.
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 2'b10 : 2'b01);
    pulse_req(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      g = exp_q.pop_front();
      c = 4'(i + 10);
      wait_deck_req(0, at);
      serve(1, c);
      check_delivery(g[1], g[0], c, g[1] && (i < 4), g[0] && (i < 4));
    end
    repeat (3) tick();
    check("contend_drained", {31'd0, o_busy}, 32'd0);

    // Round start just below the threshold does nothing.
    fill_to(39);
    i_roundStart = 1'b1;
    tick();
    i_roundStart = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen = seen | o_shuffleStart;
      tick();
    end
    check("no_shuffle_at_39", {31'd0, seen}, 32'd0);
    single_draw(1'b1, 1, 4'h4);

    // At the threshold it schedules a shuffle on the next idle cycle.
    i_roundStart = 1'b1;
    tick();
    i_roundStart = 1'b0;
    wait_shuffle(1, at);
    check("round_shuffle_latency", at, 32'd2);
    tick();
    i_shuffleDone = 1'b1;
    tick();
    i_shuffleDone = 1'b0;
    exp_count = 0;
    check("round_shuffle_count", {26'd0, o_cardsDealt}, 32'd0);
    check("round_shuffle_idle", {31'd0, o_busy}, 32'd0);

    // Empty deck: shuffle is forced, early done is ignored, request served afterwards.
    fill_to(52);
    pulse_req(1'b1, 1'b0);
    wait_shuffle(1, at);
    i_shuffleDone = 1'b1;
    tick();
    i_shuffleDone = 1'b0;
    check("done_in_shuffle_ignored", {29'd0, o_state}, 32'd5);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen = seen | o_deckReq;
      tick();
    end
    check("no_deck_req_when_full", {31'd0, seen}, 32'd0);
    check("full_count_held", {26'd0, o_cardsDealt}, 32'd52);
    check("shuf_wait_busy", {31'd0, o_busy}, 32'd1);
    i_shuffleDone = 1'b1;
    tick();
    i_shuffleDone = 1'b0;
    exp_count = 0;
    check("forced_shuffle_count", {26'd0, o_cardsDealt}, 32'd0);
    wait_deck_req(0, at);
    serve(1, 4'h8);
    check_delivery(1'b1, 1'b0, 4'h8, 1'b0, 1'b0);

    // Reset while waiting on the deck, then a late card arrives.
    pulse_req(1'b1, 1'b0);
    wait_deck_req(1, at);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_deckValid = 1'b1;
    i_deckCard  = 4'hA;
    tick();
    i_deckValid = 1'b0;
    i_deckCard  = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | o_playerValid | o_dealerValid | o_deckReq;
      tick();
    end
    check("reset_abandon_no_activity", {31'd0, seen}, 32'd0);
    check("reset_abandon_count", {26'd0, o_cardsDealt}, 32'd0);
    check("reset_abandon_busy", {31'd0, o_busy}, 32'd0);
    check("reset_abandon_card", {28'd0, o_card}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
